// File: rtl/matmul_mem_responder.sv
// Three-bank (A/B/C) word memory serving the matmul engine's read ports A/B and write port C,
// plus an arbitrated host port. Define MATMUL_MEM_STATS_EN to add saturating engine access counters.
module matmul_mem_responder #(
    parameter int DEPTH     = 256,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_read_A,
    input  logic [9:0]  mem_addr_A,
    output logic [31:0] mem_data_A,
    input  logic        mem_en_read_B,
    input  logic [9:0]  mem_addr_B,
    output logic [31:0] mem_data_B,
    input  logic        mem_en_write_C,
    input  logic [9:0]  mem_addr_C,
    input  logic [31:0] mem_data_C,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [9:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        result_valid,
    output logic        init_busy,
    output logic        addr_err
`ifdef MATMUL_MEM_STATS_EN
    ,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt
`endif
);
    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]    DEPTH_W  = 9'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] sweep_reg, sweep_next;
    logic          clearing;

    function automatic logic in_range(input logic [9:0] a);
        return {1'b0, a[7:0]} < DEPTH_W;
    endfunction

    function automatic logic in_bank(input logic [9:0] a, input logic [1:0] bank);
        return (a[9:8] == bank) && in_range(a);
    endfunction

    // ---------------- init sweep FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= (INIT_ZERO != 0) ? CLEAR : READY;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        if (state_reg == CLEAR) begin
            sweep_next = sweep_reg + IW'(1);
            if (sweep_reg == LAST_IDX)
                state_next = READY;
        end
    end

    assign clearing  = (state_reg == CLEAR);
    assign init_busy = clearing;

    // ---------------- engine decode ----------------
    logic hit_a, hit_b, hit_c, err_eng;

    assign hit_a   = !clearing && mem_en_read_A  && in_bank(mem_addr_A, 2'd0);
    assign hit_b   = !clearing && mem_en_read_B  && in_bank(mem_addr_B, 2'd1);
    assign hit_c   = !clearing && mem_en_write_C && in_bank(mem_addr_C, 2'd2);
    assign err_eng = !clearing && ((mem_en_read_A  && !hit_a) ||
                                   (mem_en_read_B  && !hit_b) ||
                                   (mem_en_write_C && !hit_c));

    // ---------------- host arbitration ----------------
    logic host_mapped, conflict, host_err, host_rd_c;

    assign host_mapped = (host_addr[9:8] != 2'b11) && in_range(host_addr);
    assign conflict    = ((host_addr[9:8] == 2'd0) && mem_en_read_A) ||
                         ((host_addr[9:8] == 2'd1) && mem_en_read_B) ||
                         ((host_addr[9:8] == 2'd2) && mem_en_write_C);
    assign host_gnt    = host_req && !clearing && !conflict;
    assign host_err    = host_gnt && !host_mapped;
    assign host_rd_c   = host_gnt && !host_we && host_mapped && (host_addr[9:8] == 2'd2);

    // ---------------- banks ----------------
    logic [2:0]    eng_en, eng_we;
    logic [IW-1:0] eng_idx [3];
    logic [31:0]   bank_q  [3];

    assign eng_en     = {mem_en_write_C, mem_en_read_B, mem_en_read_A};
    assign eng_we     = {hit_c, 1'b0, 1'b0};
    assign eng_idx[0] = mem_addr_A[IW-1:0];
    assign eng_idx[1] = mem_addr_B[IW-1:0];
    assign eng_idx[2] = mem_addr_C[IW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bank
            logic [31:0]   mem [DEPTH];
            logic [31:0]   q_reg;
            logic          host_wr, we;
            logic [IW-1:0] idx;
            logic [31:0]   wdata;

            // Single port per bank: the engine owns the address whenever its strobe is up.
            assign host_wr = host_gnt && host_we && host_mapped && (host_addr[9:8] == 2'(gi));
            assign we      = clearing || eng_we[gi] || host_wr;
            assign idx     = clearing ? sweep_reg :
                             (eng_en[gi] ? eng_idx[gi] : host_addr[IW-1:0]);
            assign wdata   = clearing ? 32'd0 : (eng_we[gi] ? mem_data_C : host_wdata);

            always_ff @(posedge clk) begin
                if (we)
                    mem[idx] <= wdata;
                q_reg <= mem[idx];
            end

            assign bank_q[gi] = q_reg;
        end
    endgenerate

    // ---------------- read return / status ----------------
    logic        a_pend_reg, a_hit_reg, b_pend_reg, b_hit_reg;
    logic        h_pend_reg, h_hit_reg;
    logic [1:0]  h_bank_reg;
    logic [31:0] a_hold_reg, b_hold_reg, h_hold_reg, h_sel;
    logic        result_valid_reg, addr_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_pend_reg       <= 1'b0;
            a_hit_reg        <= 1'b0;
            a_hold_reg       <= '0;
            b_pend_reg       <= 1'b0;
            b_hit_reg        <= 1'b0;
            b_hold_reg       <= '0;
            h_pend_reg       <= 1'b0;
            h_hit_reg        <= 1'b0;
            h_bank_reg       <= '0;
            h_hold_reg       <= '0;
            result_valid_reg <= 1'b0;
            addr_err_reg     <= 1'b0;
        end else begin
            a_pend_reg <= mem_en_read_A;
            a_hit_reg  <= hit_a;
            if (a_pend_reg)
                a_hold_reg <= mem_data_A;
            b_pend_reg <= mem_en_read_B;
            b_hit_reg  <= hit_b;
            if (b_pend_reg)
                b_hold_reg <= mem_data_B;
            h_pend_reg <= host_gnt && !host_we;
            h_hit_reg  <= host_mapped;
            h_bank_reg <= host_addr[9:8];
            if (h_pend_reg)
                h_hold_reg <= host_rdata;
            if (hit_c)
                result_valid_reg <= 1'b1;
            else if (host_rd_c)
                result_valid_reg <= 1'b0;
            if (err_eng || host_err)
                addr_err_reg <= 1'b1;
        end
    end

    always_comb begin
        h_sel = '0;
        case (h_bank_reg)
            2'd0:    h_sel = bank_q[0];
            2'd1:    h_sel = bank_q[1];
            2'd2:    h_sel = bank_q[2];
            default: h_sel = '0;
        endcase
    end

    // Fresh data straight from the bank register the cycle after a read, held value otherwise.
    assign mem_data_A   = a_pend_reg ? (a_hit_reg ? bank_q[0] : 32'd0) : a_hold_reg;
    assign mem_data_B   = b_pend_reg ? (b_hit_reg ? bank_q[1] : 32'd0) : b_hold_reg;
    assign host_rdata   = h_pend_reg ? (h_hit_reg ? h_sel : 32'd0) : h_hold_reg;
    assign host_rvalid  = h_pend_reg;
    assign result_valid = result_valid_reg;
    assign addr_err     = addr_err_reg;

`ifdef MATMUL_MEM_STATS_EN
    logic [15:0] rd_cnt_reg, wr_cnt_reg;
    logic [16:0] rd_sum;

    assign rd_sum = {1'b0, rd_cnt_reg} + 17'(hit_a) + 17'(hit_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else begin
            rd_cnt_reg <= rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
            if (hit_c && (wr_cnt_reg != 16'hFFFF))
                wr_cnt_reg <= wr_cnt_reg + 16'd1;
        end
    end

    assign stat_rd_cnt = rd_cnt_reg;
    assign stat_wr_cnt = wr_cnt_reg;
`endif
endmodule

// File: tb/tb_matmul_mem_responder.sv
// Scoreboard bench for matmul_mem_responder: stimulus pushes expected read data, a monitor pops on every response.
module tb_matmul_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_read_A, mem_en_read_B, mem_en_write_C;
    logic [9:0]  mem_addr_A, mem_addr_B, mem_addr_C;
    logic [31:0] mem_data_A, mem_data_B, mem_data_C;
    logic        host_req, host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata, host_rdata;
    logic        host_gnt, host_rvalid, result_valid, init_busy, addr_err;
`ifdef MATMUL_MEM_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

    always #5 clk = ~clk;

    matmul_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_en_read_A  (mem_en_read_A),
        .mem_addr_A     (mem_addr_A),
        .mem_data_A     (mem_data_A),
        .mem_en_read_B  (mem_en_read_B),
        .mem_addr_B     (mem_addr_B),
        .mem_data_B     (mem_data_B),
        .mem_en_write_C (mem_en_write_C),
        .mem_addr_C     (mem_addr_C),
        .mem_data_C     (mem_data_C),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .result_valid   (result_valid),
        .init_busy      (init_busy),
        .addr_err       (addr_err)
`ifdef MATMUL_MEM_STATS_EN
        ,
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_host[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic        chk_a = 1'b0;
    logic        chk_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        chk_a <= mem_en_read_A && !rst;
        chk_b <= mem_en_read_B && !rst;
    end

    always @(negedge clk) begin
        if (host_rvalid) begin
            if (q_host.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL host_rvalid_unexpected: got rdata %h with nothing expected", host_rdata);
            end else begin
                check("host_rdata", host_rdata, q_host.pop_front());
            end
        end
        if (chk_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_data_A_unexpected: got %h with nothing expected", mem_data_A);
            end else begin
                check("mem_data_A", mem_data_A, q_a.pop_front());
            end
        end
        if (chk_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_data_B_unexpected: got %h with nothing expected", mem_data_B);
            end else begin
                check("mem_data_B", mem_data_B, q_b.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!init_busy) break;
            cnt++;
        end
        tick();
    endtask

    task automatic host_write(input logic [9:0] a, input logic [31:0] d);
        logic got;
        got        = 1'b0;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = host_gnt;
            tick();
        end
        host_req = 1'b0;
        host_we  = 1'b0;
        check("host_write_gnt", 32'(got), 32'd1);
    endtask

    task automatic host_read(input logic [9:0] a, input logic [31:0] exp);
        logic got;
        got       = 1'b0;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = a;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = host_gnt;
            if (got) q_host.push_back(exp);
            tick();
        end
        host_req = 1'b0;
        check("host_read_gnt", 32'(got), 32'd1);
        check("host_rvalid_latency", 32'(host_rvalid), 32'd1);
    endtask

    task automatic eng_read_a(input logic [9:0] a, input logic [31:0] exp);
        mem_en_read_A = 1'b1;
        mem_addr_A    = a;
        q_a.push_back(exp);
        tick();
        mem_en_read_A = 1'b0;
    endtask

    task automatic eng_read_b(input logic [9:0] a, input logic [31:0] exp);
        mem_en_read_B = 1'b1;
        mem_addr_B    = a;
        q_b.push_back(exp);
        tick();
        mem_en_read_B = 1'b0;
    endtask

    task automatic eng_write_c(input logic [9:0] a, input logic [31:0] d);
        mem_en_write_C = 1'b1;
        mem_addr_C     = a;
        mem_data_C     = d;
        tick();
        mem_en_write_C = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        rst            = 1'b1;
        mem_en_read_A  = 1'b0;
        mem_en_read_B  = 1'b0;
        mem_en_write_C = 1'b0;
        mem_addr_A     = '0;
        mem_addr_B     = '0;
        mem_addr_C     = '0;
        mem_data_C     = '0;
        host_req       = 1'b0;
        host_we        = 1'b0;
        host_addr      = '0;
        host_wdata     = '0;
        repeat (3) tick();

        check("rst_mem_data_A", mem_data_A, 32'd0);
        check("rst_mem_data_B", mem_data_B, 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
        check("rst_flags", {28'd0, host_rvalid, result_valid, addr_err, init_busy}, 32'h1);

        rst = 1'b0;
        wait_init(cnt);
        check("init_busy_cycles", 32'(cnt), 32'd256);

        host_read(10'h105, 32'd0);

        host_write(10'h002, 32'h04030201);
        eng_read_a(10'h002, 32'h04030201);
        repeat (5) tick();
        check("mem_data_A_hold", mem_data_A, 32'h04030201);

        host_write(10'h0FF, 32'hA5A5F00F);
        host_read(10'h0FF, 32'hA5A5F00F);

        // Host collides with an engine B read, then wins once B goes idle.
        host_write(10'h100, 32'hCAFEBABE);
        host_req      = 1'b1;
        host_we       = 1'b0;
        host_addr     = 10'h100;
        mem_en_read_B = 1'b1;
        mem_addr_B    = 10'h101;
        q_b.push_back(32'd0);
        @(negedge clk);
        check("conflict_gnt", 32'(host_gnt), 32'd0);
        tick();
        mem_en_read_B = 1'b0;
        @(negedge clk);
        check("after_conflict_gnt", 32'(host_gnt), 32'd1);
        if (host_gnt) q_host.push_back(32'hCAFEBABE);
        tick();
        host_req = 1'b0;
        eng_read_b(10'h100, 32'hCAFEBABE);
        check("result_valid_idle", 32'(result_valid), 32'd0);
        check("addr_err_clean", 32'(addr_err), 32'd0);

        eng_write_c(10'h200, 32'h12345678);
        check("result_valid_set", 32'(result_valid), 32'd1);
        host_read(10'h200, 32'h12345678);
        check("result_valid_cleared", 32'(result_valid), 32'd0);
        check("addr_err_still_clean", 32'(addr_err), 32'd0);

        eng_read_a(10'h300, 32'd0);
        check("addr_err_set", 32'(addr_err), 32'd1);
        repeat (4) tick();
        check("addr_err_sticky", 32'(addr_err), 32'd1);

        eng_write_c(10'h010, 32'h55AA55AA);
        check("wrong_bank_write_no_valid", 32'(result_valid), 32'd0);
        host_read(10'h010, 32'd0);
        host_read(10'h3FF, 32'd0);

        // Reset mid-sweep must restart the full sweep and clear sticky flags.
        rst = 1'b1;
        tick();
        check("rst2_flags", {29'd0, result_valid, addr_err, init_busy}, 32'h1);
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(cnt);
        check("init_restart_cycles", 32'(cnt), 32'd256);
        host_read(10'h002, 32'd0);

        eng_read_a(10'h000, 32'd0);
        eng_read_a(10'h001, 32'd0);
        eng_read_a(10'h0FF, 32'd0);
        eng_read_b(10'h100, 32'd0);
        eng_read_b(10'h1FF, 32'd0);
        eng_write_c(10'h201, 32'hDEADBEEF);
        tick();
`ifdef MATMUL_MEM_STATS_EN
        check("stat_rd_cnt", 32'(stat_rd_cnt), 32'd5);
        check("stat_wr_cnt", 32'(stat_wr_cnt), 32'd1);
`endif
        check("result_valid_after_rst", 32'(result_valid), 32'd1);
        host_read(10'h201, 32'hDEADBEEF);
        check("addr_err_after_rst", 32'(addr_err), 32'd0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(q_host.size() + q_a.size() + q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
